// File: rtl/tmds_channel_encoder_pkg.sv
// Shared HDMI TMDS definitions: period-type enum, fixed control/guard-band
// words and the TERC4 code table. All words are written bit 9 .. bit 0.
package hdmi_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL      = 3'd0,
        MODE_VIDEO     = 3'd1,
        MODE_VIDEO_GB  = 3'd2,
        MODE_ISLAND    = 3'd3,
        MODE_ISLAND_GB = 3'd4
    } tmds_mode_e;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] VGB_CH02 = 10'b1011001100;
    localparam logic [9:0] VGB_CH1  = 10'b0100110011;
    localparam logic [9:0] IGB_CH12 = 10'b0100110011;

    localparam logic [9:0] TERC4_TABLE [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Per-lane symbol bus between the timing generator and the TMDS encoder.
interface tmds_channel_encoder_if #(
    parameter int BAL_W = 8
);
    logic [2:0]              mode;
    logic [7:0]              data;
    logic [1:0]              control_data;
    logic [3:0]              terc4_data;
    logic [9:0]              encoded_data;
    logic signed [BAL_W-1:0] disparity;

    modport master (
        output mode, data, control_data, terc4_data,
        input  encoded_data, disparity
    );

    modport slave (
        input  mode, data, control_data, terc4_data,
        output encoded_data, disparity
    );
endinterface

// File: rtl/tmds_channel_encoder_terc4_lut.sv
// Combinational TERC4 nibble to 10-bit symbol lookup.
module tmds_terc4_lut
    import hdmi_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [9:0] symbol
);
    assign symbol = TERC4_TABLE[nibble];
endmodule

// File: rtl/tmds_channel_encoder.sv
// Two-stage HDMI TMDS lane encoder: stage 1 does the 8b/10b transition
// minimisation, stage 2 the DC-balance decision and period-type muxing.
module tmds_channel_encoder
    import hdmi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int BAL_W   = 8
) (
    input  logic                    pix_clock,
    input  logic                    reset,
    tmds_channel_encoder_if.slave   bus
);

    localparam logic [BAL_W-1:0] TWO = BAL_W'(2);

    // ---------------- stage 1 ----------------
    tmds_mode_e mode_in;
    logic [3:0] n1_data;
    logic       use_xnor;
    logic [8:0] qm;

    always_comb begin
        mode_in  = (bus.mode > 3'd4) ? MODE_CTRL : tmds_mode_e'(bus.mode);
        n1_data  = 4'($countones(bus.data));
        use_xnor = (n1_data > 4'd4) || (n1_data == 4'd4 && !bus.data[0]);
        qm       = '0;
        qm[0]    = bus.data[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ bus.data[i]) : (qm[i-1] ^ bus.data[i]);
        qm[8]    = ~use_xnor;
    end

    tmds_mode_e s1_mode;
    logic [1:0] s1_ctrl;
    logic [3:0] s1_terc4;
    logic [8:0] s1_qm;
    logic [3:0] s1_n1;

    always_ff @(posedge pix_clock) begin
        if (reset) begin
            s1_mode  <= MODE_CTRL;
            s1_ctrl  <= '0;
            s1_terc4 <= '0;
            s1_qm    <= '0;
            s1_n1    <= '0;
        end else begin
            s1_mode  <= mode_in;
            s1_ctrl  <= bus.control_data;
            s1_terc4 <= bus.terc4_data;
            s1_qm    <= qm;
            s1_n1    <= 4'($countones(qm[7:0]));
        end
    end

    // ---------------- stage 2 ----------------
    logic [3:0] lut_in;
    logic [9:0] lut_out;

    // One LUT serves both ISLAND data and the lane-0 island guard band.
    assign lut_in = (s1_mode == MODE_ISLAND_GB) ? {2'b11, s1_ctrl} : s1_terc4;

    tmds_terc4_lut u_terc4 (
        .nibble (lut_in),
        .symbol (lut_out)
    );

    logic [9:0]              enc_q;
    logic signed [BAL_W-1:0] cnt_q;
    logic signed [BAL_W-1:0] n1s, n0s, cnt_video, cnt_next;
    logic [9:0]              q_video, sym_next;
    logic                    cnt_pos, cnt_neg;

    always_comb begin
        n1s     = BAL_W'(s1_n1);
        n0s     = BAL_W'(4'd8 - s1_n1);
        cnt_neg = cnt_q[BAL_W-1];
        cnt_pos = !cnt_q[BAL_W-1] && (cnt_q != '0);

        if (s1_n1 == 4'd4 || cnt_q == '0) begin
            q_video   = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            cnt_video = s1_qm[8] ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
        end else if ((cnt_pos && s1_n1 > 4'd4) || (cnt_neg && s1_n1 < 4'd4)) begin
            q_video   = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            cnt_video = cnt_q + (s1_qm[8] ? TWO : '0) + n0s - n1s;
        end else begin
            q_video   = {1'b0, s1_qm[8], s1_qm[7:0]};
            cnt_video = cnt_q + n1s - n0s - (s1_qm[8] ? '0 : TWO);
        end

        // Any non-VIDEO symbol restarts the running disparity.
        cnt_next = '0;
        case (s1_mode)
            MODE_VIDEO: begin
                sym_next = q_video;
                cnt_next = cnt_video;
            end
            MODE_VIDEO_GB:  sym_next = (CHANNEL == 1) ? VGB_CH1 : VGB_CH02;
            MODE_ISLAND:    sym_next = lut_out;
            MODE_ISLAND_GB: sym_next = (CHANNEL == 0) ? lut_out : IGB_CH12;
            default: begin
                case (s1_ctrl)
                    2'b00:   sym_next = CTRL_00;
                    2'b01:   sym_next = CTRL_01;
                    2'b10:   sym_next = CTRL_10;
                    default: sym_next = CTRL_11;
                endcase
            end
        endcase
    end

    always_ff @(posedge pix_clock) begin
        if (reset) begin
            enc_q <= CTRL_00;
            cnt_q <= '0;
        end else begin
            enc_q <= sym_next;
            cnt_q <= cnt_next;
        end
    end

    assign bus.encoded_data = enc_q;
    assign bus.disparity    = cnt_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Drives all three lanes with identical traffic and compares each against a
// behavioural model of the TMDS rules with a two-symbol delay line.
module tb_tmds_channel_encoder;

    logic       pix_clock = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic [7:0] data;
    logic [1:0] control_data;
    logic [3:0] terc4_data;

    always #5 pix_clock = ~pix_clock;

    tmds_channel_encoder_if #(.BAL_W(8)) bus0 ();
    tmds_channel_encoder_if #(.BAL_W(8)) bus1 ();
    tmds_channel_encoder_if #(.BAL_W(8)) bus2 ();

    assign bus0.mode = mode; assign bus0.data = data;
    assign bus0.control_data = control_data; assign bus0.terc4_data = terc4_data;
    assign bus1.mode = mode; assign bus1.data = data;
    assign bus1.control_data = control_data; assign bus1.terc4_data = terc4_data;
    assign bus2.mode = mode; assign bus2.data = data;
    assign bus2.control_data = control_data; assign bus2.terc4_data = terc4_data;

    tmds_channel_encoder #(.CHANNEL(0), .BAL_W(8)) dut0 (.pix_clock(pix_clock), .reset(reset), .bus(bus0));
    tmds_channel_encoder #(.CHANNEL(1), .BAL_W(8)) dut1 (.pix_clock(pix_clock), .reset(reset), .bus(bus1));
    tmds_channel_encoder #(.CHANNEL(2), .BAL_W(8)) dut2 (.pix_clock(pix_clock), .reset(reset), .bus(bus2));

    logic [9:0] ctrl_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    logic [9:0] terc4_tab [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    int n_vec = 0;
    int n_err = 0;

    // symbol accepted one edge ago, still inside the DUT pipeline
    logic [2:0] p_mode;
    logic [7:0] p_data;
    logic [1:0] p_ctrl;
    logic [3:0] p_terc4;
    int         cnt_m;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
        end
    endtask

    function automatic logic [9:0] ref_sym(input int lane, input logic [2:0] m, input logic [7:0] d,
                                           input logic [1:0] c, input logic [3:0] t,
                                           input int cnt_in, output int cnt_out);
        logic [9:0] r;
        logic [8:0] qm;
        logic [3:0] igb_nib;
        logic       x;
        int         n1, n0, b8;
        cnt_out = 0;
        r       = ctrl_tab[c];
        case ((m > 3'd4) ? 3'd0 : m)
            3'd1: begin
                n1 = $countones(d);
                x  = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
                qm[0] = d[0];
                for (int i = 1; i < 8; i++)
                    qm[i] = x ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
                qm[8] = ~x;
                b8 = qm[8] ? 1 : 0;
                n1 = $countones(qm[7:0]);
                n0 = 8 - n1;
                if (n1 == 4 || cnt_in == 0) begin
                    r = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
                    cnt_out = cnt_in + (b8 == 1 ? n1 - n0 : n0 - n1);
                end else if ((cnt_in > 0 && n1 > n0) || (cnt_in < 0 && n0 > n1)) begin
                    r = {1'b1, qm[8], ~qm[7:0]};
                    cnt_out = cnt_in + 2 * b8 + n0 - n1;
                end else begin
                    r = {1'b0, qm[8], qm[7:0]};
                    cnt_out = cnt_in + n1 - n0 - 2 * (1 - b8);
                end
            end
            3'd2: r = (lane == 1) ? 10'b0100110011 : 10'b1011001100;
            3'd3: r = terc4_tab[t];
            3'd4: begin
                igb_nib = {2'b11, c};
                r = (lane == 0) ? terc4_tab[igb_nib] : 10'b0100110011;
            end
            default: r = ctrl_tab[c];
        endcase
        return r;
    endfunction

    task automatic step(input logic r, input logic [2:0] m, input logic [7:0] d,
                        input logic [1:0] c, input logic [3:0] t);
        logic [9:0] want [3];
        int cnt_new;
        reset = r; mode = m; data = d; control_data = c; terc4_data = t;
        @(posedge pix_clock);
        #1;
        if (r) begin
            for (int l = 0; l < 3; l++) want[l] = 10'b1101010100;
            cnt_m = 0;
            p_mode = 3'd0; p_data = 8'd0; p_ctrl = 2'd0; p_terc4 = 4'd0;
        end else begin
            for (int l = 0; l < 3; l++)
                want[l] = ref_sym(l, p_mode, p_data, p_ctrl, p_terc4, cnt_m, cnt_new);
            cnt_m = cnt_new;
            p_mode = m; p_data = d; p_ctrl = c; p_terc4 = t;
        end
        check("enc0", int'(bus0.encoded_data), int'(want[0]));
        check("enc1", int'(bus1.encoded_data), int'(want[1]));
        check("enc2", int'(bus2.encoded_data), int'(want[2]));
        check("disp0", int'($signed(bus0.disparity)), cnt_m);
        check("disp1", int'($signed(bus1.disparity)), cnt_m);
        check("disp2", int'($signed(bus2.disparity)), cnt_m);
    endtask

    initial begin
        // reset held 3 cycles with CTRL 11 on the inputs
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 8'h00, 2'b11, 4'h0);
            check("rst_enc", int'(bus0.encoded_data), int'(10'b1101010100));
            check("rst_disp", int'($signed(bus0.disparity)), 0);
        end
        step(1'b0, 3'd0, 8'h00, 2'b11, 4'h0);
        check("post_rst_a", int'(bus0.encoded_data), int'(10'b1101010100));
        step(1'b0, 3'd0, 8'h00, 2'b11, 4'h0);
        check("post_rst_b", int'(bus0.encoded_data), int'(10'b1010101011));

        // VIDEO 0x00 x3 from CTRL
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        check("vid1", int'(bus0.encoded_data), int'(10'b0100000000));
        check("vid1_d", int'($signed(bus0.disparity)), -8);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        check("vid2", int'(bus0.encoded_data), int'(10'b1111111111));
        check("vid2_d", int'($signed(bus0.disparity)), 2);
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);
        check("vid3", int'(bus0.encoded_data), int'(10'b0100000000));
        check("vid3_d", int'($signed(bus0.disparity)), -6);
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);

        // VIDEO / VIDEO_GB / VIDEO on lane 1: guard band clears disparity
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        step(1'b0, 3'd2, 8'h00, 2'b00, 4'h0);
        check("gb_v1", int'(bus1.encoded_data), int'(10'b0100000000));
        check("gb_v1_d", int'($signed(bus1.disparity)), -8);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        check("gb_g", int'(bus1.encoded_data), int'(10'b0100110011));
        check("gb_g_d", int'($signed(bus1.disparity)), 0);
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);
        check("gb_v2", int'(bus1.encoded_data), int'(10'b0100000000));
        check("gb_v2_d", int'($signed(bus1.disparity)), -8);

        // ISLAND 0xA then ISLAND_GB with control 01
        step(1'b0, 3'd3, 8'h00, 2'b00, 4'hA);
        step(1'b0, 3'd4, 8'h00, 2'b01, 4'h0);
        check("isl_l0", int'(bus0.encoded_data), int'(10'b0110011100));
        check("isl_l2", int'(bus2.encoded_data), int'(10'b0110011100));
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);
        check("igb_l0", int'(bus0.encoded_data), int'(10'b1001110001));
        check("igb_l2", int'(bus2.encoded_data), int'(10'b0100110011));

        // mode 7 must decode as CTRL
        step(1'b0, 3'd7, 8'h5A, 2'b10, 4'h3);
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);
        check("mode7", int'(bus0.encoded_data), int'(10'b0101010100));

        // alternating VIDEO / CTRL / ISLAND with random payloads
        for (int i = 0; i < 150; i++) begin
            logic [2:0] m;
            m = (i % 3 == 0) ? 3'd1 : (i % 3 == 1) ? 3'd0 : 3'd3;
            step(1'b0, m, 8'($urandom), 2'($urandom), 4'($urandom));
        end

        // fully random modes, biased toward VIDEO runs to build up disparity
        for (int i = 0; i < 300; i++) begin
            logic [2:0] m;
            m = ($urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
            step(1'b0, m, 8'($urandom), 2'($urandom), 4'($urandom));
        end

        // reset one cycle into a VIDEO burst with nonzero disparity
        step(1'b0, 3'd0, 8'h00, 2'b00, 4'h0);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        check("pre_rst_d", int'($signed(bus0.disparity)), -8);
        step(1'b1, 3'd1, 8'h00, 2'b00, 4'h0);
        check("mid_rst_enc", int'(bus0.encoded_data), int'(10'b1101010100));
        check("mid_rst_d", int'($signed(bus0.disparity)), 0);
        step(1'b0, 3'd1, 8'h00, 2'b00, 4'h0);
        check("mid_rst_flush", int'(bus0.encoded_data), int'(10'b1101010100));
        for (int i = 0; i < 4; i++)
            step(1'b0, 3'd1, 8'($urandom), 2'b00, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
